// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: single-port RAM arbiter, data bus has priority over two round-robin instruction ports.
// Optional grant watchdog (wdog_err port, WDOG_LIMIT parameter) enabled by defining MEMARB_WDOG_EN.
module mem_arbiter
`ifdef MEMARB_WDOG_EN
#(
    parameter logic [7:0] WDOG_LIMIT = 8'd255
)
`endif
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic [1:0]  iREN,
    input  logic [63:0] iaddr,
    output logic [1:0]  iwait,
    output logic [63:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [1:0]  ramstate,
    input  logic [31:0] ramload
`ifdef MEMARB_WDOG_EN
    ,
    output logic        wdog_err
`endif
);

    localparam logic [1:0] ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   igrant;
    logic   next_igrant;
    logic   last_i;
    logic   next_last_i;
    logic   access;
    logic   wdog_fire;

    assign access = (ramstate == ACCESS);

`ifdef MEMARB_WDOG_EN
    logic [7:0] wdog_cnt;

    // Counts stalled grant cycles; a hung grant is abandoned and flagged until reset.
    assign wdog_fire = (state != IDLE) && (wdog_cnt == WDOG_LIMIT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wdog_cnt <= 8'd0;
            wdog_err <= 1'b0;
        end else if (state == IDLE) begin
            wdog_cnt <= 8'd0;
        end else begin
            if (!access) begin
                wdog_cnt <= wdog_cnt + 8'd1;
            end
            if (wdog_fire) begin
                wdog_err <= 1'b1;
            end
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            igrant <= 1'b0;
            last_i <= 1'b1;
        end else begin
            state  <= next_state;
            igrant <= next_igrant;
            last_i <= next_last_i;
        end
    end

    always_comb begin
        next_state  = state;
        next_igrant = igrant;
        next_last_i = last_i;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = 32'd0;
        ramstore    = 32'd0;
        dwait       = 1'b1;
        dload       = 32'd0;
        iwait       = 2'b11;
        iload       = 64'd0;

        case (state)
            IDLE: begin
                if (dREN || dWEN) begin
                    next_state = DGRANT;
                end else if (|iREN) begin
                    next_state = IGRANT;
                    // Both asking: serve the core that was not served last.
                    next_igrant = (&iREN) ? ~last_i : iREN[1];
                end
            end

            DGRANT: begin
                if (!(dREN || dWEN)) begin
                    next_state = IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    if (wdog_fire) begin
                        next_state = IDLE;
                    end else if (access) begin
                        dwait      = 1'b0;
                        dload      = ramload;
                        next_state = IDLE;
                    end
                end
            end

            IGRANT: begin
                if (!iREN[igrant]) begin
                    next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = igrant ? iaddr[63:32] : iaddr[31:0];
                    if (wdog_fire) begin
                        next_state = IDLE;
                    end else if (access) begin
                        iwait       = igrant ? 2'b01 : 2'b10;
                        iload       = igrant ? {ramload, 32'd0} : {32'd0, ramload};
                        next_last_i = igrant;
                        next_state  = IDLE;
                    end
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: directed scenarios plus randomized masters checked by a queue scoreboard.
module tb_mem_arbiter;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        ireq0 = 1'b0, ireq1 = 1'b0;
    logic [31:0] iaddr0 = 32'd0, iaddr1 = 32'd0;
    logic [1:0]  iREN;
    logic [63:0] iaddr;
    logic [1:0]  iwait;
    logic [63:0] iload;
    logic        dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] daddr = 32'd0, dstore = 32'd0;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore;
    logic [1:0]  ramstate = FREE;
    logic [31:0] ramload;
`ifdef MEMARB_WDOG_EN
    logic        wdog_err;
`endif

    assign iREN  = {ireq1, ireq0};
    assign iaddr = {iaddr1, iaddr0};

    mem_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramstate(ramstate), .ramload(ramload)
`ifdef MEMARB_WDOG_EN
        , .wdog_err(wdog_err)
`endif
    );

    always #5 CLK = ~CLK;

    // RAM model: instruction space (bit 31 set) returns ~addr, data space is a word array.
    logic [31:0] dmem [0:1023];
    assign ramload = ramaddr[31] ? ~ramaddr : dmem[ramaddr[11:2]];

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= 32'hC0DE_0000 | 32'(i);
        end else if (ramWEN && ramstate == ACCESS) begin
            dmem[ramaddr[11:2]] <= ramstore;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    // Scoreboard state
    typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; int snap; } dtx_t;
    typedef struct { logic [31:0] addr; int snap; } itx_t;
    dtx_t dq[$];
    itx_t iq0[$];
    itx_t iq1[$];
    int icomp0 = 0, icomp1 = 0;
    logic sb_on = 1'b0;
    logic rnd_done = 1'b0;
    logic [31:0] ref_mem [0:63];
    dtx_t dmon;

    task automatic mon_core(input int c);
        itx_t e;
        logic [31:0] mine, other;
        int oc;
        mine  = (c == 0) ? iload[31:0] : iload[63:32];
        other = (c == 0) ? iload[63:32] : iload[31:0];
        oc    = (c == 0) ? icomp1 : icomp0;
        if ((c == 0 && iq0.size() == 0) || (c == 1 && iq1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL i_spurious core%0d at %0t: got completion, want none", c, $time);
            return;
        end
        if (c == 0) e = iq0.pop_front();
        else        e = iq1.pop_front();
        chk("i_addr", ramaddr, e.addr);
        chk("i_data", mine, ~e.addr);
        chk("i_other_load", other, 32'd0);
        chk("i_round_robin", 32'((oc - e.snap) <= 1), 32'd1);
        if (c == 0) icomp0++;
        else        icomp1++;
    endtask

    always @(negedge CLK) begin
        if (sb_on) begin
            if (dwait) chk("d_idle_load", dload, 32'd0);
            if (iwait[0]) chk("i0_idle_load", iload[31:0], 32'd0);
            if (iwait[1]) chk("i1_idle_load", iload[63:32], 32'd0);
            chk("single_grant", 32'($countones({~iwait, ~dwait}) <= 1), 32'd1);
            if (!dwait) begin
                if (dq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL d_spurious at %0t: got completion, want none", $time);
                end else begin
                    dmon = dq.pop_front();
                    chk("d_addr", ramaddr, dmon.addr);
                    if (dmon.wr) begin
                        chk("d_wen", 32'(ramWEN), 32'd1);
                        chk("d_wdata", ramstore, dmon.data);
                    end else begin
                        chk("d_ren", 32'(ramREN), 32'd1);
                        chk("d_rdata", dload, dmon.data);
                    end
                    chk("d_priority", 32'((icomp0 + icomp1 - dmon.snap) <= 1), 32'd1);
                end
            end
            if (!iwait[0]) mon_core(0);
            if (!iwait[1]) mon_core(1);
        end
    end

    task automatic data_master();
        dtx_t e;
        int idx, t;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) cyc();
            idx    = $urandom_range(0, 63);
            e.wr   = ($urandom_range(0, 1) == 1);
            e.addr = 32'h800 + 32'(idx * 4);
            e.snap = icomp0 + icomp1;
            if (e.wr) begin
                e.data = $urandom;
                ref_mem[idx] = e.data;
            end else begin
                e.data = ref_mem[idx];
            end
            dq.push_back(e);
            daddr  = e.addr;
            dstore = e.wr ? e.data : $urandom;
            dWEN   = e.wr;
            dREN   = ~e.wr | ($urandom_range(0, 1) == 1);
            t = 0;
            forever begin
                smp();
                if (!dwait) break;
                t++;
                if (t > 500) begin
                    checks++;
                    failures++;
                    $display("FAIL d_timeout at %0t: got no completion, want dwait=0", $time);
                    break;
                end
            end
            cyc();
            dREN = 1'b0;
            dWEN = 1'b0;
        end
    endtask

    task automatic core_master(input int c);
        itx_t e;
        int t;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) cyc();
            e.addr = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
            e.snap = (c == 0) ? icomp1 : icomp0;
            if (c == 0) begin
                iq0.push_back(e);
                iaddr0 = e.addr;
                ireq0  = 1'b1;
            end else begin
                iq1.push_back(e);
                iaddr1 = e.addr;
                ireq1  = 1'b1;
            end
            t = 0;
            forever begin
                smp();
                if (!iwait[c]) break;
                t++;
                if (t > 500) begin
                    checks++;
                    failures++;
                    $display("FAIL i_timeout core%0d at %0t: got no completion, want iwait=0", c, $time);
                    break;
                end
            end
            cyc();
            if (c == 0) ireq0 = 1'b0;
            else        ireq1 = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no end of test, want completion");
        $fatal(1, "bench timeout");
    end

    logic [1:0] exp_iw [0:5];
    int wd_len;

    initial begin
        #1 nRST = 1'b0;
        repeat (2) smp();
        chk("rst_ren", 32'(ramREN), 32'd0);
        chk("rst_wen", 32'(ramWEN), 32'd0);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_iwait", 32'(iwait), 32'd3);
        chk("rst_addr", ramaddr, 32'd0);
        cyc();
        nRST = 1'b1;

        // Data write, ACCESS on second grant cycle
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; ramstate = BUSY;
        smp();
        chk("t1_idle_wen", 32'(ramWEN), 32'd0);
        cyc(); smp();
        chk("t1_g1_wen", 32'(ramWEN), 32'd1);
        chk("t1_g1_addr", ramaddr, 32'h100);
        chk("t1_g1_store", ramstore, 32'hDEAD_BEEF);
        chk("t1_g1_dwait", 32'(dwait), 32'd1);
        cyc(); ramstate = ACCESS; smp();
        chk("t1_g2_dwait", 32'(dwait), 32'd0);
        chk("t1_g2_wen", 32'(ramWEN), 32'd1);
        cyc(); dWEN = 1'b0; ramstate = FREE; smp();
        chk("t1_idle_after_wen", 32'(ramWEN), 32'd0);
        chk("t1_idle_after_addr", ramaddr, 32'd0);
        chk("t1_idle_after_dwait", 32'(dwait), 32'd1);

        // Both cores held, RAM always ready: core0, core1, core0
        cyc();
        iaddr0 = 32'h8000_0010; iaddr1 = 32'h8000_0020; ireq0 = 1'b1; ireq1 = 1'b1; ramstate = ACCESS;
        exp_iw[0] = 2'b11; exp_iw[1] = 2'b10; exp_iw[2] = 2'b11;
        exp_iw[3] = 2'b01; exp_iw[4] = 2'b11; exp_iw[5] = 2'b10;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) cyc();
            smp();
            chk("t2_iwait", 32'(iwait), 32'(exp_iw[k]));
            if (exp_iw[k] == 2'b10) begin
                chk("t2_iload0", iload[31:0], ~32'h8000_0010);
                chk("t2_iload1_zero", iload[63:32], 32'd0);
            end
            if (exp_iw[k] == 2'b01) chk("t2_iload1", iload[63:32], ~32'h8000_0020);
        end
        cyc(); ireq0 = 1'b0; ireq1 = 1'b0;

        // Data and core0 together: data first, then core0
        dREN = 1'b1; daddr = 32'h200; ireq0 = 1'b1;
        smp();
        chk("t3_idle_ren", 32'(ramREN), 32'd0);
        cyc(); smp();
        chk("t3_dgrant_dwait", 32'(dwait), 32'd0);
        chk("t3_dgrant_ren", 32'(ramREN), 32'd1);
        chk("t3_dgrant_iwait", 32'(iwait), 32'd3);
        chk("t3_dgrant_dload", dload, 32'hC0DE_0080);
        cyc(); dREN = 1'b0; smp();
        chk("t3_gap_iwait", 32'(iwait), 32'd3);
        cyc(); smp();
        chk("t3_igrant_iwait", 32'(iwait), 32'd2);
        chk("t3_igrant_ren", 32'(ramREN), 32'd1);
        chk("t3_igrant_addr", ramaddr, 32'h8000_0010);
        cyc(); ireq0 = 1'b0; smp();

        // Core1 stalled by BUSY, then withdraws
        cyc(); ireq1 = 1'b1; ramstate = BUSY; smp();
        cyc(); smp();
        chk("t4_busy_ren", 32'(ramREN), 32'd1);
        chk("t4_busy_addr", ramaddr, 32'h8000_0020);
        chk("t4_busy_iwait", 32'(iwait), 32'd3);
        cyc(); smp();
        chk("t4_busy_hold_ren", 32'(ramREN), 32'd1);
        cyc(); ireq1 = 1'b0; smp();
        chk("t4_drop_ren", 32'(ramREN), 32'd0);
        chk("t4_drop_iwait", 32'(iwait), 32'd3);
        cyc(); dREN = 1'b1; daddr = 32'h200; ramstate = ACCESS; smp();
        chk("t4_idle_dwait", 32'(dwait), 32'd1);
        cyc(); smp();
        chk("t4_next_dgrant", 32'(dwait), 32'd0);
        cyc(); dREN = 1'b0; smp();

        // Reset in the middle of a stalled data write
        cyc(); dWEN = 1'b1; daddr = 32'h300; dstore = 32'h1234_5678; ramstate = BUSY; smp();
        cyc(); smp();
        chk("t5_pre_wen", 32'(ramWEN), 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("t5_rst_wen", 32'(ramWEN), 32'd0);
        chk("t5_rst_dwait", 32'(dwait), 32'd1);
        chk("t5_rst_iwait", 32'(iwait), 32'd3);
        cyc(); nRST = 1'b1; smp();
        chk("t5_release_idle_wen", 32'(ramWEN), 32'd0);
        cyc(); smp();
        chk("t5_regrant_wen", 32'(ramWEN), 32'd1);
        cyc(); dWEN = 1'b0; smp();

`ifdef MEMARB_WDOG_EN
        // Grant stuck on BUSY: watchdog abandons it and flags
        cyc(); dREN = 1'b1; daddr = 32'h200; ramstate = BUSY; smp();
        wd_len = 0;
        for (int k = 0; k < 400; k++) begin
            cyc(); smp();
            if (!ramREN) break;
            wd_len++;
        end
        chk("wd_grant_len", 32'(wd_len >= 255 && wd_len <= 256), 32'd1);
        chk("wd_wait_held", 32'(dwait), 32'd1);
        cyc(); dREN = 1'b0; smp();
        chk("wd_err_set", 32'(wdog_err), 32'd1);
        repeat (3) cyc();
        smp();
        chk("wd_err_sticky", 32'(wdog_err), 32'd1);
        cyc(); nRST = 1'b0; #1;
        chk("wd_err_cleared", 32'(wdog_err), 32'd0);
        cyc(); nRST = 1'b1;
`else
        wd_len = 0;
`endif

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(512 + i);
        cyc();
        sb_on = 1'b1;
        fork
            begin
                fork
                    data_master();
                    core_master(0);
                    core_master(1);
                join
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3, 4, 5: ramstate = ACCESS;
                        6, 7:             ramstate = BUSY;
                        8:                ramstate = FREE;
                        default:          ramstate = ERROR;
                    endcase
                    cyc();
                end
            end
        join
        repeat (4) cyc();
        sb_on = 1'b0;
        chk("dq_drained", 32'(dq.size()), 32'd0);
        chk("iq0_drained", 32'(iq0.size()), 32'd0);
        chk("iq1_drained", 32'(iq1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
